// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: request/data bus from four requesters and the valid/ready output toward one consumer
interface rr_mux_arbiter_if #(parameter int DATA_WIDTH = 32);
  logic [3:0]            req;
  logic [DATA_WIDTH-1:0] data_0;
  logic [DATA_WIDTH-1:0] data_1;
  logic [DATA_WIDTH-1:0] data_2;
  logic [DATA_WIDTH-1:0] data_3;
  logic [3:0]            gnt;
  logic [1:0]            sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  modport master (
    output req, data_0, data_1, data_2, data_3, out_ready,
    input  gnt, sel, out_valid, out_data
  );
  modport slave (
    input  req, data_0, data_1, data_2, data_3, out_ready,
    output gnt, sel, out_valid, out_data
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin pick of one of four requesters into a registered valid/ready output
module rr_mux_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  rr_mux_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_ptr;
  logic [1:0]            r_sel;
  logic [DATA_WIDTH-1:0] r_data;
  logic [7:0]            w_req2;
  logic [3:0]            w_rot;
  logic [1:0]            w_off;
  logic [1:0]            w_win;
  logic                  w_cap;
  logic [DATA_WIDTH-1:0] w_data;
  // w_rot[k] is the request of index ptr+k, so the lowest set bit is the round-robin winner
  assign w_req2 = {bus.req, bus.req};
  assign w_rot  = w_req2[r_ptr +: 4];
  assign w_off  = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign w_win  = r_ptr + w_off;
  assign w_cap  = (|bus.req) && (r_state == IDLE || bus.out_ready);
  assign w_data = w_win == 2'd0 ? bus.data_0 :
                  w_win == 2'd1 ? bus.data_1 :
                  w_win == 2'd2 ? bus.data_2 : bus.data_3;
  assign bus.gnt       = (w_cap && !rst) ? 4'b0001 << w_win : 4'b0000;
  assign bus.sel       = r_sel;
  assign bus.out_valid = r_state == BUSY;
  assign bus.out_data  = r_data;
  // next state: capture always fills the output; an accept with nothing new empties it
  always_comb begin
    w_state_next = r_state;
    if (w_cap) w_state_next = BUSY;
    else if (r_state == BUSY && bus.out_ready) w_state_next = IDLE;
  end
  // state register; reset discards any held word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_state_next;
  end
  // capture the winner's word and move priority just past the winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= 2'd0;
      r_sel  <= 2'd0;
      r_data <= '0;
    end else if (w_cap) begin
      r_ptr  <= w_win + 2'd1;
      r_sel  <= w_win;
      r_data <= w_data;
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: scoreboard bench with a queue-based round-robin reference model
module tb_rr_mux_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  rr_mux_arbiter_if #(.DATA_WIDTH(32)) bus();
  rr_mux_arbiter #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic [1:0] sel; logic [31:0] data;} exp_t;
  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          m_ptr = 0;
  bit          m_busy = 0;
  logic [31:0] m_last = 0;
  int          g_win = -1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] dat(int i);
    case (i)
      0: return bus.data_0;
      1: return bus.data_1;
      2: return bus.data_2;
      default: return bus.data_3;
    endcase
  endfunction
  task automatic set_dat(int i, logic [31:0] v);
    case (i)
      0: bus.data_0 = v;
      1: bus.data_1 = v;
      2: bus.data_2 = v;
      default: bus.data_3 = v;
    endcase
  endtask
  task automatic model_reset();
    q.delete();
    m_ptr = 0;
    m_busy = 0;
    m_last = 0;
  endtask
  // one clock: predict grant from the rules, check it, enqueue the captured word, then retire the granted request
  task automatic step();
    int win;
    bit cap;
    logic [3:0] eg;
    @(negedge clk);
    win = -1;
    for (int k = 0; k < 4; k++)
      if (win < 0 && bus.req[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    cap = win >= 0 && (!m_busy || bus.out_ready);
    eg = cap ? 4'(1 << win) : 4'b0000;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("out_valid", 32'(bus.out_valid), 32'(m_busy));
    g_win = cap ? win : -1;
    if (cap) begin
      q.push_back('{2'(win), dat(win)});
      m_ptr = (win + 1) % 4;
      m_busy = 1;
    end else if (m_busy && bus.out_ready) m_busy = 0;
    @(posedge clk);
    #1;
    if (g_win >= 0) bus.req[g_win] = 1'b0;
  endtask
  // monitor: whatever the DUT presents must be the oldest outstanding word; pop on transfer
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %h expected none", bus.out_data);
        end else begin
          chk("out_data", bus.out_data, q[0].data);
          chk("sel", 32'(bus.sel), 32'(q[0].sel));
          if (bus.out_ready) begin
            m_last = q[0].data;
            void'(q.pop_front());
          end
        end
      end else chk("idle_out_data", bus.out_data, m_last);
    end
  end
  initial begin
    bus.req = 4'b0000;
    bus.data_0 = '0;
    bus.data_1 = '0;
    bus.data_2 = '0;
    bus.data_3 = '0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    bus.req = 4'b0100;
    bus.data_2 = 32'hDEADBEEF;
    bus.out_ready = 1'b1;
    step();
    step();
    bus.req = 4'b1001;
    step();
    step();
    step();
    for (int i = 0; i < 4; i++) set_dat(i, 32'h1000_0000 + 32'(i));
    bus.req = 4'b1000;
    step();
    for (int n = 0; n < 8; n++) begin
      bus.req = 4'b1111;
      step();
    end
    bus.req = 4'b0000;
    step();
    step();
    bus.data_1 = 32'hAAAA5555;
    bus.req = 4'b0010;
    step();
    bus.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      bus.req = 4'b1111;
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.req = 4'b0000;
    step();
    step();
    step();
    bus.req = 4'b0001;
    bus.out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_sel", 32'(bus.sel), 32'd0);
    chk("arst_out_data", bus.out_data, 32'd0);
    chk("arst_gnt", 32'(bus.gnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.req = 4'b1111;
    bus.out_ready = 1'b1;
    step();
    for (int n = 0; n < 400; n++) begin
      bus.out_ready = $urandom_range(0, 3) != 0;
      for (int i = 0; i < 4; i++)
        if (!bus.req[i] && $urandom_range(0, 1) == 1) begin
          set_dat(i, $urandom);
          bus.req[i] = 1'b1;
        end
      step();
    end
    bus.out_ready = 1'b1;
    for (int n = 0; n < 8; n++) step();
    bus.req = 4'b0000;
    for (int n = 0; n < 3; n++) step();
    chk("leftover_words", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
